// File: rtl/oc_pkg.sv
// -----------------------------------------------------------------------------
// oc_pkg
// Shared types and constants for the output-compare unit.
//   oc_mode_e  : compare action applied to oc_o when an entry fires
//   oc_state_e : control FSM states (IDLE, ARM, PULSE)
//   OCTMR_*    : timer-select encodings
//   OC_DEF_*   : default parameter values for the top level
// -----------------------------------------------------------------------------
package oc_pkg;

    localparam int OC_DEF_FIFO_DEPTH = 4;
    localparam int OC_DEF_TW         = 16;
    localparam int OC_DEF_PULSE_LEN  = 4;

    localparam logic [1:0] OCTMR_OFF    = 2'b00;
    localparam logic [1:0] OCTMR_T0     = 2'b01;
    localparam logic [1:0] OCTMR_T1     = 2'b10;
    localparam logic [1:0] OCTMR_T0_ALT = 2'b11;

    typedef enum logic [1:0] {
        OC_SET = 2'b00,
        OC_CLR = 2'b01,
        OC_TGL = 2'b10,
        OC_PLS = 2'b11
    } oc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        PULSE = 2'b10
    } oc_state_e;

endpackage

// File: rtl/oc_fifo.sv
// -----------------------------------------------------------------------------
// oc_fifo
// Synchronous FIFO of compare values with flush, entry count and sticky
// overflow. A second write source (reload_i) re-queues the entry being popped
// in the same cycle, so the head can be rotated to the tail.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i (fire-and-forget: no back-pressure, a push
//                that finds no free slot is dropped and flagged in ovf_o)
//   wdata_i      value to write
//   pop_i        discard the head entry (ignored while empty)
//   reload_i     with pop_i: write the popped head back at the tail
//   flush_i      empty the FIFO and clear ovf_o; beats push/pop/reload
//   head_o       current head entry
//   count_o      number of stored entries
//   empty_o      registered, count_o == 0
//   full_o       registered, count_o == DEPTH
//   ovf_o        sticky: a push was dropped for lack of space
// -----------------------------------------------------------------------------
module oc_fifo #(
    parameter int DEPTH = 4,
    parameter int TW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [TW-1:0]              wdata_i,
    input  logic                       pop_i,
    input  logic                       reload_i,
    input  logic                       flush_i,
    output logic [TW-1:0]              head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rld_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, ovf_q, ovf_d;
    logic          pop_ok, rld_ok, bus_ok;

    // A reload needs the slot freed by its own pop, so a bus write can only
    // share a pop-while-full cycle when no reload claims that slot.
    assign pop_ok  = pop_i && !empty_q;
    assign rld_ok  = reload_i && pop_ok;
    assign bus_ok  = push_i && (!full_q || (pop_ok && !rld_ok));
    // Bus write takes the tail slot; the reload lands right behind it.
    assign rld_ptr = bus_ok ? wptr_q + PW'(1) : wptr_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            wptr_d  = wptr_q + PW'(bus_ok) + PW'(rld_ok);
            rptr_d  = rptr_q + PW'(pop_ok);
            count_d = count_q + CW'(bus_ok) + CW'(rld_ok) - CW'(pop_ok);
            ovf_d   = ovf_q | (push_i && !bus_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (bus_ok) mem_q[wptr_q] <= wdata_i;
            if (rld_ok) mem_q[rld_ptr] <= mem_q[rptr_q];
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/output_compare_fifo.sv
// -----------------------------------------------------------------------------
// output_compare_fifo
// Timer-driven output compare. Compare values are queued in a FIFO; whenever
// the selected timer changes to a value equal to the head entry, oc_o is
// updated according to OCM and the entry is popped.
// Build option: define OC_AUTORELOAD_EN to re-queue every entry fired in
// toggle mode, giving a free-running cyclic waveform.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   t_val_bi_0/1          timer 0 / timer 1 count values
//   OCTMR                 timer select (00 off, 01 t0, 10 t1, 11 t0)
//   OCM                   mode (00 set, 01 clear, 10 toggle, 11 pulse)
//   wr_i, wdata_i         push a compare value (one per high cycle)
//   clr_i                 flush FIFO and clear OCOV
//   oc_o                  compare output pin
//   match_o               one-cycle strobe per fired compare
//   OCBE, OCBF, OCOV      FIFO empty / full / sticky overflow
//   OCCNT                 FIFO entry count
//   state_o               control FSM state (debug)
// -----------------------------------------------------------------------------
module output_compare_fifo
    import oc_pkg::*;
#(
    parameter int FIFO_DEPTH = OC_DEF_FIFO_DEPTH,
    parameter int TW         = OC_DEF_TW,
    parameter int PULSE_LEN  = OC_DEF_PULSE_LEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TW-1:0]                 t_val_bi_0,
    input  logic [TW-1:0]                 t_val_bi_1,
    input  logic [1:0]                    OCTMR,
    input  logic [1:0]                    OCM,
    input  logic                          wr_i,
    input  logic [TW-1:0]                 wdata_i,
    input  logic                          clr_i,
    output logic                          oc_o,
    output logic                          match_o,
    output logic                          OCBE,
    output logic                          OCBF,
    output logic                          OCOV,
    output logic [$clog2(FIFO_DEPTH):0]   OCCNT,
    output logic [1:0]                    state_o
);

    localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCW-1:0] PLOAD = PCW'(PULSE_LEN - 1);

    oc_state_e      state_q, state_d;
    oc_mode_e       mode;
    logic           oc_q, oc_d;
    logic           match_q;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0]  t_sel, t_prev_q, head;
    logic           enabled, tick, match, reload;

    assign enabled = (OCTMR != OCTMR_OFF);
    assign mode    = oc_mode_e'(OCM);

    always_comb begin
        t_sel = t_val_bi_0;
        unique case (OCTMR)
            OCTMR_OFF: t_sel = '0;
            OCTMR_T1:  t_sel = t_val_bi_1;
            default:   t_sel = t_val_bi_0;
        endcase
    end

    // Only a change of timer value may fire, so a prescaled timer sitting on
    // one value triggers once. A flush in the same cycle suppresses the fire.
    assign tick  = (t_sel != t_prev_q);
    assign match = enabled && tick && !OCBE && (t_sel == head)
                   && (state_q != IDLE) && !clr_i;

`ifdef OC_AUTORELOAD_EN
    assign reload = match && (state_q == ARM) && (mode == OC_TGL);
`else
    assign reload = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        oc_d    = oc_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            IDLE: begin
                if (enabled) state_d = ARM;
            end
            ARM: begin
                if (match) begin
                    unique case (mode)
                        OC_SET: oc_d = 1'b1;
                        OC_CLR: oc_d = 1'b0;
                        OC_TGL: oc_d = ~oc_q;
                        OC_PLS: begin
                            oc_d    = 1'b1;
                            pcnt_d  = PLOAD;
                            state_d = PULSE;
                        end
                    endcase
                end
            end
            PULSE: begin
                // Any fire during a pulse retriggers it, whatever OCM now says.
                if (match) begin
                    oc_d   = 1'b1;
                    pcnt_d = PLOAD;
                end else if (pcnt_q == '0) begin
                    oc_d    = 1'b0;
                    state_d = ARM;
                end else begin
                    pcnt_d = pcnt_q - PCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Disabling abandons any pulse and freezes the pin where it is.
        if (!enabled) begin
            state_d = IDLE;
            oc_d    = oc_q;
            pcnt_d  = pcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            oc_q     <= 1'b0;
            match_q  <= 1'b0;
            pcnt_q   <= '0;
            t_prev_q <= '0;
        end else begin
            state_q  <= state_d;
            oc_q     <= oc_d;
            match_q  <= match;
            pcnt_q   <= pcnt_d;
            t_prev_q <= t_sel;
        end
    end

    oc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .TW    (TW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (wr_i),
        .wdata_i  (wdata_i),
        .pop_i    (match),
        .reload_i (reload),
        .flush_i  (clr_i),
        .head_o   (head),
        .count_o  (OCCNT),
        .empty_o  (OCBE),
        .full_o   (OCBF),
        .ovf_o    (OCOV)
    );

    assign oc_o    = oc_q;
    assign match_o = match_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_output_compare_fifo.sv
module tb_output_compare_fifo;
    import oc_pkg::*;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] t0, t1;
    logic [1:0]    OCTMR, OCM;
    logic          wr_i, clr_i;
    logic [TW-1:0] wdata_i;
    logic          oc_o, match_o, OCBE, OCBF, OCOV;
    logic [2:0]    OCCNT;
    logic [1:0]    state_o;

    int checks = 0;
    int failures = 0;
    int match_seen = 0;
    logic [0:0] exp_q[$];
    logic       model_oc;

    output_compare_fifo #(.FIFO_DEPTH(4), .TW(TW), .PULSE_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .t_val_bi_0(t0), .t_val_bi_1(t1),
        .OCTMR(OCTMR), .OCM(OCM), .wr_i(wr_i), .wdata_i(wdata_i), .clr_i(clr_i),
        .oc_o(oc_o), .match_o(match_o), .OCBE(OCBE), .OCBF(OCBF), .OCOV(OCOV),
        .OCCNT(OCCNT), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; t0 = '0; t1 = '0; OCTMR = 2'b00; OCM = 2'b00;
        wr_i = 1'b0; wdata_i = '0; clr_i = 1'b0;
        exp_q.delete();
        model_oc = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- drivers ----------------
    task automatic push_val(input logic [TW-1:0] v);
        wr_i = 1'b1;
        wdata_i = v;
        step();
        wr_i = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    // Every match_o strobe pops the expected oc_o value for that fire.
    always @(negedge clk) begin
        logic [0:0] e;
        if (rst_n && match_o) begin
            match_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL match_unexpected: match_o=1 oc_o=%b, required no match", oc_o);
            end else begin
                e = exp_q.pop_front();
                if (oc_o !== e) begin
                    failures++;
                    $display("FAIL match_oc: oc_o=%b required=%b", oc_o, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (oc_o !== 1'b0)    begin failures++; $display("FAIL reset_oc: got=%b req=0", oc_o); end
        checks++; if (match_o !== 1'b0) begin failures++; $display("FAIL reset_match: got=%b req=0", match_o); end
        checks++; if (OCBE !== 1'b1)    begin failures++; $display("FAIL reset_ocbe: got=%b req=1", OCBE); end
        checks++; if (OCBF !== 1'b0)    begin failures++; $display("FAIL reset_ocbf: got=%b req=0", OCBF); end
        checks++; if (OCOV !== 1'b0)    begin failures++; $display("FAIL reset_ocov: got=%b req=0", OCOV); end
        checks++; if (OCCNT !== 3'd0)   begin failures++; $display("FAIL reset_occnt: got=%0d req=0", OCCNT); end
        checks++; if (state_o !== IDLE) begin failures++; $display("FAIL reset_state: got=%0d req=%0d", state_o, IDLE); end
    endtask

    task automatic test_toggle();
        do_reset();
        OCTMR = 2'b01; OCM = 2'b10; t0 = '0;
        push_val(16'd10); push_val(16'd20); push_val(16'd30);
        match_seen = 0;
        for (int v = 0; v <= 40; v++) begin
            t0 = 16'(v);
            if (v == 10 || v == 20 || v == 30) begin
                model_oc = ~model_oc;
                exp_q.push_back(model_oc);
            end
            step();
        end
        step();
        checks++; if (match_seen != 3)    begin failures++; $display("FAIL tgl_strobes: got=%0d req=3", match_seen); end
        checks++; if (oc_o !== 1'b1)      begin failures++; $display("FAIL tgl_oc_final: got=%b req=1", oc_o); end
        checks++; if (OCBE !== 1'b1)      begin failures++; $display("FAIL tgl_ocbe: got=%b req=1", OCBE); end
        checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL tgl_missed: pending=%0d req=0", exp_q.size()); end
    endtask

    task automatic test_prescale();
        do_reset();
        OCTMR = 2'b01; OCM = 2'b00; t0 = 16'd5;
        push_val(16'd10); push_val(16'd50); step();
        checks++; if (OCCNT !== 3'd2) begin failures++; $display("FAIL pre_cnt_before: got=%0d req=2", OCCNT); end
        match_seen = 0;
        t0 = 16'd10;
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) step();
        step();
        checks++; if (match_seen != 1)   begin failures++; $display("FAIL pre_strobes: got=%0d req=1", match_seen); end
        checks++; if (OCCNT !== 3'd1)    begin failures++; $display("FAIL pre_cnt_after: got=%0d req=1", OCCNT); end
        checks++; if (oc_o !== 1'b1)     begin failures++; $display("FAIL pre_oc: got=%b req=1", oc_o); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pre_missed: pending=%0d req=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) push_val(16'(i));
        checks++; if (OCBF !== 1'b1)  begin failures++; $display("FAIL ov_full: got=%b req=1", OCBF); end
        checks++; if (OCOV !== 1'b0)  begin failures++; $display("FAIL ov_early: got=%b req=0", OCOV); end
        push_val(16'd5);
        checks++; if (OCOV !== 1'b1)  begin failures++; $display("FAIL ov_set: got=%b req=1", OCOV); end
        checks++; if (OCCNT !== 3'd4) begin failures++; $display("FAIL ov_cnt: got=%0d req=4", OCCNT); end
        checks++; if (OCBF !== 1'b1)  begin failures++; $display("FAIL ov_full2: got=%b req=1", OCBF); end
        clr_i = 1'b1; step(); clr_i = 1'b0;
        checks++; if (OCBE !== 1'b1)  begin failures++; $display("FAIL clr_ocbe: got=%b req=1", OCBE); end
        checks++; if (OCOV !== 1'b0)  begin failures++; $display("FAIL clr_ocov: got=%b req=0", OCOV); end
        checks++; if (OCCNT !== 3'd0) begin failures++; $display("FAIL clr_cnt: got=%0d req=0", OCCNT); end
        checks++; if (OCBF !== 1'b0)  begin failures++; $display("FAIL clr_ocbf: got=%b req=0", OCBF); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        OCTMR = 2'b01; OCM = 2'b00; t0 = 16'd100;
        for (int i = 1; i <= 4; i++) push_val(16'(i));
        step();
        match_seen = 0;
        // Pop (timer hits head 1) and push in the same cycle while full.
        t0 = 16'd1; wr_i = 1'b1; wdata_i = 16'd9;
        exp_q.push_back(1'b1);
        step(); wr_i = 1'b0;
        checks++; if (OCCNT !== 3'd4) begin failures++; $display("FAIL fpp_cnt: got=%0d req=4", OCCNT); end
        checks++; if (OCBF !== 1'b1)  begin failures++; $display("FAIL fpp_full: got=%b req=1", OCBF); end
        checks++; if (OCOV !== 1'b0)  begin failures++; $display("FAIL fpp_ocov: got=%b req=0", OCOV); end
        checks++; if (oc_o !== 1'b1)  begin failures++; $display("FAIL fpp_oc: got=%b req=1", oc_o); end
        // Flush with a matching head and a write: flush wins, no strobe.
        OCM = 2'b01; t0 = 16'd2; clr_i = 1'b1; wr_i = 1'b1; wdata_i = 16'd77;
        step(); clr_i = 1'b0; wr_i = 1'b0;
        step();
        checks++; if (OCBE !== 1'b1)     begin failures++; $display("FAIL cpri_ocbe: got=%b req=1", OCBE); end
        checks++; if (OCCNT !== 3'd0)    begin failures++; $display("FAIL cpri_cnt: got=%0d req=0", OCCNT); end
        checks++; if (oc_o !== 1'b1)     begin failures++; $display("FAIL cpri_oc: got=%b req=1", oc_o); end
        checks++; if (match_seen != 1)   begin failures++; $display("FAIL cpri_strobes: got=%0d req=1", match_seen); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cpri_missed: pending=%0d req=0", exp_q.size()); end
    endtask

    task automatic test_pulse();
        int high;
        do_reset();
        OCTMR = 2'b01; OCM = 2'b11; t0 = '0;
        push_val(16'd7); step();
        high = 0;
        for (int v = 0; v <= 20; v++) begin
            t0 = 16'(v);
            if (v == 7) exp_q.push_back(1'b1);
            step();
            if (oc_o === 1'b1) high++;
        end
        checks++; if (high != 4)        begin failures++; $display("FAIL pls_high: got=%0d req=4", high); end
        checks++; if (oc_o !== 1'b0)    begin failures++; $display("FAIL pls_end_oc: got=%b req=0", oc_o); end
        checks++; if (state_o !== ARM)  begin failures++; $display("FAIL pls_state: got=%0d req=%0d", state_o, ARM); end
        // Second entry arrives two cycles into the pulse: 2 + 4 high cycles.
        push_val(16'd30); push_val(16'd32);
        high = 0;
        for (int v = 21; v <= 45; v++) begin
            t0 = 16'(v);
            if (v == 30 || v == 32) exp_q.push_back(1'b1);
            step();
            if (oc_o === 1'b1) high++;
        end
        checks++; if (high != 6)         begin failures++; $display("FAIL pls_retrig_high: got=%0d req=6", high); end
        checks++; if (OCBE !== 1'b1)     begin failures++; $display("FAIL pls_ocbe: got=%b req=1", OCBE); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pls_missed: pending=%0d req=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        OCTMR = 2'b01; OCM = 2'b11; t0 = '0;
        push_val(16'd50); push_val(16'd60); step();
        t0 = 16'd50; exp_q.push_back(1'b1);
        step(); step();
        checks++; if (state_o !== PULSE) begin failures++; $display("FAIL rmp_pre_state: got=%0d req=%0d", state_o, PULSE); end
        rst_n = 1'b0;
        #2;
        checks++; if (oc_o !== 1'b0)    begin failures++; $display("FAIL rmp_oc: got=%b req=0", oc_o); end
        checks++; if (OCBE !== 1'b1)    begin failures++; $display("FAIL rmp_ocbe: got=%b req=1", OCBE); end
        checks++; if (OCCNT !== 3'd0)   begin failures++; $display("FAIL rmp_cnt: got=%0d req=0", OCCNT); end
        checks++; if (state_o !== IDLE) begin failures++; $display("FAIL rmp_state: got=%0d req=%0d", state_o, IDLE); end
        do_reset();
    endtask

`ifdef OC_AUTORELOAD_EN
    task automatic test_autoreload();
        do_reset();
        OCTMR = 2'b01; OCM = 2'b10; t0 = '0;
        push_val(16'd4); push_val(16'd8); step();
        match_seen = 0;
        for (int p = 0; p < 4; p++) begin
            for (int v = 0; v <= 15; v++) begin
                t0 = 16'(v);
                if (v == 4 || v == 8) begin
                    model_oc = ~model_oc;
                    exp_q.push_back(model_oc);
                end
                step();
                if (v == 15) begin
                    checks++; if (OCCNT !== 3'd2) begin failures++; $display("FAIL arl_cnt: period=%0d got=%0d req=2", p, OCCNT); end
                end
            end
        end
        checks++; if (match_seen != 8)   begin failures++; $display("FAIL arl_strobes: got=%0d req=8", match_seen); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL arl_missed: pending=%0d req=0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_toggle();
        test_prescale();
        test_overflow();
        test_full_push_pop();
        test_pulse();
        test_reset_mid_pulse();
`ifdef OC_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
